generador_imm: RTL and testbench
================================

Name: generador_imm

Overview:
- RV64 immediate generator for the decode stage.
- Takes a 32-bit RISC-V instruction, selects the immediate format from the opcode, and assembles the immediate.
- Sign-extends the result to 64 bits and registers it for the execute stage.
- Unrecognised opcodes produce zero.

Parameters:
- XLEN, 64, output immediate width; only 64 is supported.
- ILEN, 32, instruction width; fixed at 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  Offset holds an instruction to decode this cycle.
- Offset  input  32  instruction word; bit 31 is MSB, bits 6:0 are the opcode.
- out_valid  output  1  Inmediato holds a freshly decoded immediate.
- Inmediato  output  64  sign-extended immediate.

Behaviour:
- Reset: on a rising clk with rst=1, Inmediato<=0 and out_valid<=0. Reset has priority over in_valid. A reset mid-stream discards the pending result.
- Latency: exactly one cycle. On a rising clk with rst=0:
  - out_valid<=in_valid.
  - If in_valid=1, Inmediato<=imm(Offset).
  - If in_valid=0, Inmediato holds its previous value.
- No back-pressure; a new instruction is accepted every cycle.
- imm() is a combinational decode on opcode Offset[6:0]:
  - I-type (LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, JALR 1100111): sext(Offset[31:20]).
  - S-type (STORE 0100011): sext({Offset[31:25],Offset[11:7]}).
  - B-type (BRANCH 1100011): sext({Offset[31],Offset[7],Offset[30:25],Offset[11:8],1'b0}).
  - U-type (LUI 0110111, AUIPC 0010111): sext({Offset[31:12],12'b0}). Bits 63:32 replicate Offset[31].
  - J-type (JAL 1101111): sext({Offset[31],Offset[19:12],Offset[20],Offset[30:21],1'b0}).
  - Any other opcode, including R-type 0110011 and non-standard codes such as 0110000: all zeros.
- Sign bit is always Offset[31]. rd/rs/funct fields are ignored.
- Shift immediates (OP-IMM funct3 001/101) receive the plain I-type value; downstream masks shamt.
- No latches; default branch of the decode yields zero.

Optional Feature:
- Macro GENIMM_ILLEGAL_FLAG_EN.
- When defined: adds output port illegal (1 bit), registered with the same timing as out_valid.
  - Asserted when in_valid=1 and the opcode is outside the nine listed opcodes or R-type.
  - Cleared by reset.
  - Inmediato is still zero in that case.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package gen_imm_pkg:
  - opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP).
  - enum imm_fmt_e {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE}.
- One natural sub-module: imm_fmt_decode, a combinational map from opcode to imm_fmt_e (plus the illegal flag).
- The top contains the assembly/sign-extension mux and the output registers.

Test Plan:
- Reset held 2 cycles, then released with in_valid=0 -> Inmediato=0, out_valid=0.
- I-type load, one cycle after in_valid=1:
  - Offset=0x00A02083 (lw x1,10(x0)) -> Inmediato=0x000000000000000A, out_valid=1.
  - Offset=0x00F02103 -> 0x000000000000000F.
  - Offset=0xFFF00093 (addi x1,x0,-1) -> 0xFFFFFFFFFFFFFFFF.
- S-type and B-type:
  - Offset=0x00302123 (store, imm 2) -> 0x0000000000000002.
  - Offset=0xFE000EE3 (beq -4) -> 0xFFFFFFFFFFFFFFFC.
- U-type and J-type:
  - Offset=0x123450B7 -> 0x0000000012345000.
  - Offset=0x800000B7 -> 0xFFFFFFFF80000000.
  - Offset=0x0080006F (jal +8) -> 0x0000000000000008.
- Unknown opcode: Offset=0x02000030 -> Inmediato=0; illegal=1 when GENIMM_ILLEGAL_FLAG_EN is defined.
- Back-to-back and reset interaction:
  - 10, 15, 2 on consecutive cycles -> outputs 10, 15, 2 on the following consecutive cycles.
  - rst asserted together with in_valid -> next cycle Inmediato=0, out_valid=0.
  - in_valid dropped -> Inmediato holds its value and out_valid=0.

Source files
------------

// File: rtl/gen_imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gen_imm_pkg
// Description : Shared RV64 opcode constants and immediate-format enum
// Revision    : 1.0
// ============================================================================
package gen_imm_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd5
    } imm_fmt_e;

endpackage
`default_nettype wire

// File: rtl/imm_fmt_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_fmt_decode
// Description : Opcode to immediate-format map; illegal flag only when
//               GENIMM_ILLEGAL_FLAG_EN is defined
// Revision    : 1.0
// ============================================================================
module imm_fmt_decode
    import gen_imm_pkg::*;
(
    input  logic [6:0] opcode_i,
    output imm_fmt_e   fmt_o
`ifdef GENIMM_ILLEGAL_FLAG_EN
    ,
    output logic       illegal_o
`endif
);

    logic illegal_d;

    always_comb begin
        fmt_o     = FMT_NONE;
        illegal_d = 1'b0;
        case (opcode_i)
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR: fmt_o = FMT_I;
            OPC_STORE:                                    fmt_o = FMT_S;
            OPC_BRANCH:                                   fmt_o = FMT_B;
            OPC_LUI, OPC_AUIPC:                           fmt_o = FMT_U;
            OPC_JAL:                                      fmt_o = FMT_J;
            // R-type carries no immediate but is a legal instruction
            OPC_OP:                                       fmt_o = FMT_NONE;
            default:                                      illegal_d = 1'b1;
        endcase
    end

`ifdef GENIMM_ILLEGAL_FLAG_EN
    assign illegal_o = illegal_d;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_d;
`endif

endmodule
`default_nettype wire

// File: rtl/generador_imm.sv
`default_nettype none
// ============================================================================
// Module      : generador_imm
// Description : RV64 decode-stage immediate generator, one-cycle registered;
//               GENIMM_ILLEGAL_FLAG_EN adds a registered illegal output
// Revision    : 1.0
// ============================================================================
module generador_imm
    import gen_imm_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [ILEN-1:0] Offset,
    output logic            out_valid,
    output logic [XLEN-1:0] Inmediato
`ifdef GENIMM_ILLEGAL_FLAG_EN
    ,
    output logic            illegal
`endif
);

    imm_fmt_e        imm_fmt;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] imm_q;
    logic            valid_q;
    logic            sgn;

    assign sgn = Offset[ILEN-1];

`ifdef GENIMM_ILLEGAL_FLAG_EN
    logic illegal_dec;
    logic illegal_q;

    imm_fmt_decode u_dec (
        .opcode_i  (Offset[6:0]),
        .fmt_o     (imm_fmt),
        .illegal_o (illegal_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= in_valid & illegal_dec;
    end

    assign illegal = illegal_q;
`else
    imm_fmt_decode u_dec (
        .opcode_i (Offset[6:0]),
        .fmt_o    (imm_fmt)
    );
`endif

    always_comb begin
        imm_d = '0;
        case (imm_fmt)
            FMT_I: imm_d = {{(XLEN-12){sgn}}, Offset[31:20]};
            FMT_S: imm_d = {{(XLEN-12){sgn}}, Offset[31:25], Offset[11:7]};
            FMT_B: imm_d = {{(XLEN-13){sgn}}, Offset[31], Offset[7],
                            Offset[30:25], Offset[11:8], 1'b0};
            FMT_U: imm_d = {{(XLEN-32){sgn}}, Offset[31:12], 12'b0};
            FMT_J: imm_d = {{(XLEN-21){sgn}}, Offset[31], Offset[19:12],
                            Offset[20], Offset[30:21], 1'b0};
            default: imm_d = '0;
        endcase
    end

    // Immediate is held while idle so execute can reuse it without a restall
    always_ff @(posedge clk) begin
        if (rst) begin
            imm_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) imm_q <= imm_d;
        end
    end

    assign Inmediato = imm_q;
    assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_generador_imm.sv
`default_nettype none
// ============================================================================
// Module      : tb_generador_imm
// Description : Self-checking bench for generador_imm (directed + random)
// Revision    : 1.0
// ============================================================================
module tb_generador_imm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] Offset = '0;
    logic        out_valid;
    logic [63:0] Inmediato;
`ifdef GENIMM_ILLEGAL_FLAG_EN
    logic        illegal;
`endif

    generador_imm dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .Offset    (Offset),
        .out_valid (out_valid),
        .Inmediato (Inmediato)
`ifdef GENIMM_ILLEGAL_FLAG_EN
        ,
        .illegal   (illegal)
`endif
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] exp_imm  = '0;
    logic        exp_vld  = 1'b0;
    logic        exp_ill  = 1'b0;

    // Reference: immediate value built arithmetically from the ISA field weights
    function automatic logic [63:0] ref_imm(input logic [31:0] ins);
        longint s;
        longint v;
        s = ins[31] ? 64'sd1 : 64'sd0;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111:
                v = -s * 2048 + longint'(ins[30:20]);
            7'b0100011:
                v = -s * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
            7'b1100011:
                v = -s * 4096 + longint'(ins[7]) * 2048
                    + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            7'b0110111, 7'b0010111:
                v = -s * 64'sd2147483648 + longint'(ins[30:12]) * 4096;
            7'b1101111:
                v = -s * 1048576 + longint'(ins[19:12]) * 4096
                    + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            default:
                v = 0;
        endcase
        return 64'(v);
    endfunction

    function automatic logic ref_illegal(input logic [6:0] op);
        logic [6:0] legal [10];
        legal = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b0100011,
                  7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};
        foreach (legal[k]) if (legal[k] == op) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, compare 1 time unit after rising edge
    task automatic step(input logic r, input logic v, input logic [31:0] ins);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        Offset   = ins;
        @(posedge clk);
        #1;
        if (r) begin
            exp_imm = '0;
            exp_vld = 1'b0;
            exp_ill = 1'b0;
        end else begin
            exp_vld = v;
            exp_ill = v & ref_illegal(ins[6:0]);
            if (v) exp_imm = ref_imm(ins);
        end
        check("imm", Inmediato, exp_imm);
        check("valid", {63'b0, out_valid}, {63'b0, exp_vld});
`ifdef GENIMM_ILLEGAL_FLAG_EN
        check("illegal", {63'b0, illegal}, {63'b0, exp_ill});
`endif
    endtask

    initial begin
        logic [6:0]  ops [12];
        logic [31:0] rnd;
        ops = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
                7'b0110000, 7'b1111111};

        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("reset_imm", Inmediato, 64'h0);
        check("reset_valid", {63'b0, out_valid}, 64'h0);

        step(1'b0, 1'b1, 32'h00A02083);
        check("lw10", Inmediato, 64'h000000000000000A);
        check("lw10_valid", {63'b0, out_valid}, 64'h1);
        step(1'b0, 1'b1, 32'h00F02103);
        check("lw15", Inmediato, 64'h000000000000000F);
        step(1'b0, 1'b1, 32'hFFF00093);
        check("addi_m1", Inmediato, 64'hFFFFFFFFFFFFFFFF);
        step(1'b0, 1'b1, 32'h00302123);
        check("store2", Inmediato, 64'h0000000000000002);
        step(1'b0, 1'b1, 32'hFE000EE3);
        check("beq_m4", Inmediato, 64'hFFFFFFFFFFFFFFFC);
        step(1'b0, 1'b1, 32'h123450B7);
        check("lui_pos", Inmediato, 64'h0000000012345000);
        step(1'b0, 1'b1, 32'h800000B7);
        check("lui_neg", Inmediato, 64'hFFFFFFFF80000000);
        step(1'b0, 1'b1, 32'h0080006F);
        check("jal8", Inmediato, 64'h0000000000000008);
        step(1'b0, 1'b1, 32'h02000030);
        check("unknown", Inmediato, 64'h0);
`ifdef GENIMM_ILLEGAL_FLAG_EN
        check("unknown_ill", {63'b0, illegal}, 64'h1);
`endif
        step(1'b0, 1'b1, 32'h00B50533);
        check("rtype", Inmediato, 64'h0);

        step(1'b0, 1'b1, 32'h00A02083);
        check("b2b_10", Inmediato, 64'd10);
        step(1'b0, 1'b1, 32'h00F02103);
        check("b2b_15", Inmediato, 64'd15);
        step(1'b0, 1'b1, 32'h00302123);
        check("b2b_2", Inmediato, 64'd2);
        step(1'b0, 1'b0, 32'hFFF00093);
        check("hold", Inmediato, 64'd2);
        check("hold_valid", {63'b0, out_valid}, 64'h0);
        step(1'b1, 1'b1, 32'h00A02083);
        check("rst_prio", Inmediato, 64'h0);
        check("rst_prio_valid", {63'b0, out_valid}, 64'h0);

        for (int i = 0; i < 400; i++) begin
            rnd = $urandom();
            if ($urandom_range(0, 3) != 0) rnd[6:0] = ops[$urandom_range(0, 11)];
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), rnd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
